// File: rtl/smallseg_g0_chain_walker_if.sv
// Handshake and search-stage bundle for smallseg_g0_chain_walker.
// The walker connects through the slave modport; the hash stage / search stage side uses master.
interface smallseg_g0_chain_walker_if;
   logic         in_valid;
   logic         in_ready;
   logic [103:0] in_tuple;
   logic [10:0]  in_head;
   logic [10:0]  search_index;
   logic [103:0] search_tuple;
   logic         match_in;
   logic [10:0]  ruleID_in;
   logic [10:0]  next_index_in;
   logic         out_valid;
   logic         out_ready;
   logic         out_match;
   logic [10:0]  out_ruleID;
   logic [3:0]   out_hops;
   logic         out_overflow;

   modport slave (
      input  in_valid, in_tuple, in_head, match_in, ruleID_in, next_index_in, out_ready,
      output in_ready, search_index, search_tuple, out_valid, out_match, out_ruleID,
             out_hops, out_overflow
   );

   modport master (
      output in_valid, in_tuple, in_head, match_in, ruleID_in, next_index_in, out_ready,
      input  in_ready, search_index, search_tuple, out_valid, out_match, out_ruleID,
             out_hops, out_overflow
   );
endinterface

// File: rtl/smallseg_g0_chain_walker.sv
// Chain-walk controller for the small-segment G0 table search stage: follows next_index links
// until hit, end of chain or hop limit. Optional feature macro: G0_WALK_STATS_EN (result counters).
module smallseg_g0_chain_walker #(
   parameter int          SUBSET_NUM = 0,
   parameter int          TABLE_NUM  = 0,
   parameter int          SEARCH_LAT = 2,
   parameter int          MAX_HOPS   = 8,
   parameter logic [10:0] NULL_INDEX = 11'h7FF
) (
   input  logic                          clk,
   input  logic                          rst,
   smallseg_g0_chain_walker_if.slave     bus
`ifdef G0_WALK_STATS_EN
   ,
   output logic [31:0]                   stat_lookups,
   output logic [31:0]                   stat_hits,
   output logic [31:0]                   stat_overflows
`endif
);

   localparam int                WAIT_W    = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SEARCH_LAT - 1);
   localparam logic [3:0]        HOP_LIMIT = 4'(MAX_HOPS);

   if (MAX_HOPS < 1 || MAX_HOPS > 15 || SEARCH_LAT < 1 || SUBSET_NUM < 0 || TABLE_NUM < 0)
   begin : g_bad_params
      $error("smallseg_g0_chain_walker: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_DONE} state_t;

   state_t            state_q;
   logic [10:0]       search_index_q;
   logic [103:0]      search_tuple_q;
   logic [3:0]        hop_q;
   logic [WAIT_W-1:0] wait_q;
   logic              out_valid_q;
   logic              out_match_q;
   logic              out_overflow_q;
   logic [10:0]       out_rule_q;
   logic [3:0]        out_hops_q;

   // NOTE: state is written only with non-blocking assignments so every register samples
   // pre-edge values; blocking writes here would make results depend on statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         search_index_q <= '0;
         search_tuple_q <= '0;
         hop_q          <= '0;
         wait_q         <= '0;
         out_valid_q    <= 1'b0;
         out_match_q    <= 1'b0;
         out_overflow_q <= 1'b0;
         out_rule_q     <= '0;
         out_hops_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  search_tuple_q <= bus.in_tuple;
                  hop_q          <= '0;
                  if (bus.in_head == NULL_INDEX) begin
                     // Empty bucket: result is posted on the next cycle with out_valid_q still low here.
                     state_q        <= S_DONE;
                     out_match_q    <= 1'b0;
                     out_overflow_q <= 1'b0;
                     out_rule_q     <= '0;
                     out_hops_q     <= '0;
                  end else begin
                     search_index_q <= bus.in_head;
                     hop_q          <= 4'd1;
                     wait_q         <= '0;
                     state_q        <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               wait_q <= wait_q + 1'b1;
               if (wait_q == WAIT_LAST) state_q <= S_EVAL;
            end

            S_EVAL: begin
               if (bus.match_in) begin
                  state_q        <= S_DONE;
                  out_valid_q    <= 1'b1;
                  out_match_q    <= 1'b1;
                  out_overflow_q <= 1'b0;
                  out_rule_q     <= bus.ruleID_in;
                  out_hops_q     <= hop_q;
               end else if (bus.next_index_in == NULL_INDEX || hop_q == HOP_LIMIT) begin
                  state_q        <= S_DONE;
                  out_valid_q    <= 1'b1;
                  out_match_q    <= 1'b0;
                  out_overflow_q <= (bus.next_index_in != NULL_INDEX);
                  out_rule_q     <= '0;
                  out_hops_q     <= hop_q;
               end else begin
                  search_index_q <= bus.next_index_in;
                  hop_q          <= hop_q + 4'd1;
                  wait_q         <= '0;
                  state_q        <= S_WAIT;
               end
            end

            S_DONE: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready     = (state_q == S_IDLE);
   assign bus.search_index = search_index_q;
   assign bus.search_tuple = search_tuple_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_match    = out_match_q;
   assign bus.out_ruleID   = out_rule_q;
   assign bus.out_hops     = out_hops_q;
   assign bus.out_overflow = out_overflow_q;

`ifdef G0_WALK_STATS_EN
   logic        handshake;
   logic [31:0] lookups_q, hits_q, overflows_q;

   assign handshake = (state_q == S_DONE) && out_valid_q && bus.out_ready;

   // Saturating counters, one step per accepted result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lookups_q   <= '0;
         hits_q      <= '0;
         overflows_q <= '0;
      end else if (handshake) begin
         if (lookups_q != '1)                       lookups_q   <= lookups_q + 32'd1;
         if (out_match_q && hits_q != '1)           hits_q      <= hits_q + 32'd1;
         if (out_overflow_q && overflows_q != '1)   overflows_q <= overflows_q + 32'd1;
      end
   end

   assign stat_lookups   = lookups_q;
   assign stat_hits      = hits_q;
   assign stat_overflows = overflows_q;
`endif

endmodule

// File: tb/tb_smallseg_g0_chain_walker.sv
// Directed bench for smallseg_g0_chain_walker; the search stage is a table indexed by search_index.
module tb_smallseg_g0_chain_walker;
   localparam logic [10:0] NUL = 11'h7FF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   smallseg_g0_chain_walker_if bus();

`ifdef G0_WALK_STATS_EN
   logic [31:0] stat_lookups, stat_hits, stat_overflows;
`endif

   smallseg_g0_chain_walker #(
      .SUBSET_NUM(0), .TABLE_NUM(0), .SEARCH_LAT(2), .MAX_HOPS(8), .NULL_INDEX(11'h7FF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef G0_WALK_STATS_EN
      ,
      .stat_lookups(stat_lookups),
      .stat_hits(stat_hits),
      .stat_overflows(stat_overflows)
`endif
   );

   always #5 clk = ~clk;

   logic        mt_tbl  [2048];
   logic [10:0] rid_tbl [2048];
   logic [10:0] nxt_tbl [2048];
   logic [10:0] idx_q [$];

   assign bus.match_in      = mt_tbl[bus.search_index];
   assign bus.ruleID_in     = rid_tbl[bus.search_index];
   assign bus.next_index_in = nxt_tbl[bus.search_index];

   task automatic clear_tables;
      for (int i = 0; i < 2048; i++) begin
         mt_tbl[i]  = 1'b0;
         rid_tbl[i] = 11'd0;
         nxt_tbl[i] = NUL;
      end
   endtask

   task automatic do_accept(input logic [10:0] head, input logic [103:0] tup);
      bus.in_head  = head;
      bus.in_tuple = tup;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   // Returns cycles from acceptance edge to out_valid, or -1 if the budget expires.
   task automatic wait_valid(output int cyc);
      logic [10:0] last;
      cyc  = -1;
      idx_q.delete();
      last = bus.search_index;
      idx_q.push_back(last);
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk); #1;
         if (bus.search_index !== last) begin
            last = bus.search_index;
            idx_q.push_back(last);
         end
         if (bus.out_valid === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic do_release;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic check_result(input string nm, input int cyc, input int exp_cyc,
                               input logic m, input logic [10:0] r, input logic [3:0] h,
                               input logic o);
      n_checks++;
      if (cyc !== exp_cyc) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_cyc); end
      n_checks++;
      if (bus.out_match !== m) begin n_fail++; $display("FAIL %s out_match: got %0b want %0b", nm, bus.out_match, m); end
      n_checks++;
      if (bus.out_ruleID !== r) begin n_fail++; $display("FAIL %s out_ruleID: got %0d want %0d", nm, bus.out_ruleID, r); end
      n_checks++;
      if (bus.out_hops !== h) begin n_fail++; $display("FAIL %s out_hops: got %0d want %0d", nm, bus.out_hops, h); end
      n_checks++;
      if (bus.out_overflow !== o) begin n_fail++; $display("FAIL %s out_overflow: got %0b want %0b", nm, bus.out_overflow, o); end
   endtask

   task automatic check_reset_values(input string nm);
      n_checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_match, bus.out_overflow} !== 4'b1000) begin
         n_fail++;
         $display("FAIL %s flags {in_ready,out_valid,out_match,out_overflow}: got %b want 1000", nm,
                  {bus.in_ready, bus.out_valid, bus.out_match, bus.out_overflow});
      end
      n_checks++;
      if ({bus.out_ruleID, bus.out_hops, bus.search_index} !== 26'd0) begin
         n_fail++;
         $display("FAIL %s ruleID/hops/search_index: got %0d/%0d/%0d want 0/0/0", nm,
                  bus.out_ruleID, bus.out_hops, bus.search_index);
      end
      n_checks++;
      if (bus.search_tuple !== 104'd0) begin
         n_fail++; $display("FAIL %s search_tuple: got %h want 0", nm, bus.search_tuple);
      end
   endtask

   task automatic test_reset;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_head = '0; bus.in_tuple = '0;
      clear_tables();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_values("reset_release");
   endtask

   task automatic test_hit;
      int cyc;
      logic [103:0] tup;
      tup = {8'd6, 16'd80, 16'd1234, 32'h0A000001, 32'hC0A80001};
      clear_tables();
      mt_tbl[5] = 1'b1; rid_tbl[5] = 11'd42;
      do_accept(11'd5, tup);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hit in_ready after accept: got %b want 0", bus.in_ready); end
      wait_valid(cyc);
      check_result("hit", cyc, 3, 1'b1, 11'd42, 4'd1, 1'b0);
      n_checks++;
      if (bus.search_tuple !== tup) begin n_fail++; $display("FAIL hit search_tuple: got %h want %h", bus.search_tuple, tup); end
      do_release();
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hit release: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_chain_miss;
      int cyc;
      clear_tables();
      nxt_tbl[5] = 11'd9; nxt_tbl[9] = NUL;
      do_accept(11'd5, {8'd17, 16'd53, 16'd999, 32'h08080808, 32'h0A0A0A0A});
      wait_valid(cyc);
      check_result("chain_miss", cyc, 6, 1'b0, 11'd0, 4'd2, 1'b0);
      n_checks++;
      if (idx_q.size() != 2 || idx_q[0] !== 11'd5 || idx_q[1] !== 11'd9) begin
         n_fail++; $display("FAIL chain_miss search_index sequence: got %p want 5,9", idx_q);
      end
      do_release();
   endtask

   task automatic test_null_head;
      int cyc;
      clear_tables();
      do_accept(NUL, {8'd1, 16'd0, 16'd0, 32'h1, 32'h2});
      wait_valid(cyc);
      check_result("null_head", cyc, 1, 1'b0, 11'd0, 4'd0, 1'b0);
      n_checks++;
      if (bus.search_index !== 11'd9) begin n_fail++; $display("FAIL null_head search_index: got %0d want 9", bus.search_index); end
      do_release();
   endtask

   task automatic test_overflow;
      int cyc;
      clear_tables();
      nxt_tbl[3] = 11'd4; nxt_tbl[4] = 11'd3;
      do_accept(11'd3, {8'd6, 16'd443, 16'd5000, 32'h01020304, 32'h05060708});
      wait_valid(cyc);
      check_result("overflow", cyc, 24, 1'b0, 11'd0, 4'd8, 1'b1);
      do_release();
   endtask

   task automatic test_match_priority;
      int cyc;
      // Match and end-of-chain in the same entry.
      clear_tables();
      mt_tbl[6] = 1'b1; rid_tbl[6] = 11'd77; nxt_tbl[6] = NUL;
      do_accept(11'd6, {8'd6, 16'd1, 16'd2, 32'h3, 32'h4});
      wait_valid(cyc);
      check_result("prio_null", cyc, 3, 1'b1, 11'd77, 4'd1, 1'b0);
      do_release();
      // Match on the last allowed hop of a non-terminated chain 20..27.
      clear_tables();
      for (int k = 0; k < 8; k++) nxt_tbl[20 + k] = 11'(21 + k);
      mt_tbl[27] = 1'b1; rid_tbl[27] = 11'd500;
      do_accept(11'd20, {8'd6, 16'd5, 16'd6, 32'h7, 32'h8});
      wait_valid(cyc);
      check_result("prio_ovf", cyc, 24, 1'b1, 11'd500, 4'd8, 1'b0);
      do_release();
   endtask

   task automatic test_back_to_back;
      int cyc;
      clear_tables();
      mt_tbl[5] = 1'b1; rid_tbl[5] = 11'd42;
      mt_tbl[6] = 1'b1; rid_tbl[6] = 11'd66;
      do_accept(11'd5, {8'd6, 16'd10, 16'd20, 32'h30, 32'h40});
      wait_valid(cyc);
      bus.in_head = 11'd6; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_ruleID !== 11'd42
             || bus.search_index !== 11'd5) begin
            n_fail++;
            $display("FAIL backpressure hold cycle %0d: got valid=%b ready=%b rule=%0d idx=%0d want 1/0/42/5",
                     i, bus.out_valid, bus.in_ready, bus.out_ruleID, bus.search_index);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.search_index !== 11'd5) begin
         n_fail++;
         $display("FAIL backpressure handshake: got valid=%b ready=%b idx=%0d want 0/1/5",
                  bus.out_valid, bus.in_ready, bus.search_index);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.search_index !== 11'd6) begin
         n_fail++; $display("FAIL back_to_back accept: got ready=%b idx=%0d want 0/6", bus.in_ready, bus.search_index);
      end
      wait_valid(cyc);
      check_result("back_to_back", cyc, 3, 1'b1, 11'd66, 4'd1, 1'b0);
      do_release();
   endtask

   task automatic test_reset_mid_walk;
      int cyc;
      clear_tables();
      nxt_tbl[5] = 11'd9; nxt_tbl[9] = NUL;
      do_accept(11'd5, {8'd6, 16'd7, 16'd8, 32'h9, 32'hA});
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.search_index !== 11'd9) begin n_fail++; $display("FAIL mid_walk hop2 index: got %0d want 9", bus.search_index); end
      rst = 1'b1;
      #2;
      check_reset_values("mid_walk_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_walk idle cycle %0d: got valid=%b ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
         end
      end
      mt_tbl[9] = 1'b1; rid_tbl[9] = 11'd123;
      do_accept(11'd9, {8'd6, 16'd1, 16'd1, 32'h1, 32'h1});
      wait_valid(cyc);
      check_result("after_reset", cyc, 3, 1'b1, 11'd123, 4'd1, 1'b0);
      do_release();
`ifdef G0_WALK_STATS_EN
      n_checks++;
      if (stat_lookups !== 32'd1 || stat_hits !== 32'd1 || stat_overflows !== 32'd0) begin
         n_fail++; $display("FAIL stats after reset: got %0d/%0d/%0d want 1/1/0", stat_lookups, stat_hits, stat_overflows);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_hit();
      test_chain_miss();
      test_null_head();
      test_overflow();
      test_match_priority();
      test_back_to_back();
      test_reset_mid_walk();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
